// File: rtl/serial_parallel_pkg.sv
// Shared BPSK datapath constants and the framer state type.
package serial_parallel_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } sp_state_e;

  localparam int         DEFAULT_WIDTH     = 16;
  localparam int         DEFAULT_SYNC_LEN  = 8;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD5;

endpackage

// File: rtl/serial_parallel_sync_detector.sv
// Frame-sync hunter: shifts strobed bits in at the MSB and flags the edge whose
// incoming bit completes the sync pattern (first-received bit ends up in bit 0).
module sync_detector #(
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hD5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic strobe,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_LEN-1:0] shift_q;
  logic [SYNC_LEN-1:0] shift_d;

  assign shift_d = {bit_in, shift_q[SYNC_LEN-1:1]};
  // Match is judged on the value being shifted in, so the FSM can lock on the same edge.
  assign match   = strobe && (shift_d == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
    end else if (strobe) begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/serial_parallel.sv
// Serial-to-parallel deframer: optional sync hunt, LSB-first word assembly and a
// one-deep output register with valid/ready handshake and overrun reporting.
module serial_parallel
  import serial_parallel_pkg::*;
#(
  parameter int                  WIDTH     = DEFAULT_WIDTH,
  parameter int                  SYNC_EN   = 1,
  parameter int                  SYNC_LEN  = DEFAULT_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEFAULT_SYNC_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_signal,
  input  logic             next,
  input  logic             data_ready,
  output logic [WIDTH-1:0] parallel_data,
  output logic             data_valid,
  output logic             sync_lock,
  output logic             overrun
);

  localparam int             CW          = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT    = CW'(WIDTH - 1);
  localparam sp_state_e      RESET_STATE = (SYNC_EN != 0) ? HUNT : COLLECT;
  localparam logic           RESET_LOCK  = (SYNC_EN == 0);

  sp_state_e        state;
  logic [CW-1:0]    bit_count;
  logic [WIDTH-2:0] word_q;
  logic             hunt_strobe;
  logic             sync_match;
  logic             word_done;

  assign hunt_strobe = next && (state == HUNT);
  assign word_done   = next && (state == COLLECT) && (bit_count == LAST_BIT);

  sync_detector #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detector (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != HUNT),
    .strobe (hunt_strobe),
    .bit_in (serial_signal),
    .match  (sync_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET_STATE;
      sync_lock     <= RESET_LOCK;
      bit_count     <= '0;
      word_q        <= '0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (hunt_strobe && sync_match) begin
            state     <= COLLECT;
            sync_lock <= 1'b1;
            bit_count <= '0;
          end
        end
        COLLECT: begin
          if (word_done) begin
            // The final bit goes straight to the output; an unaccepted word is overwritten.
            parallel_data <= {serial_signal, word_q};
            data_valid    <= 1'b1;
            overrun       <= data_valid && !data_ready;
            bit_count     <= '0;
            if (SYNC_EN != 0) begin
              state     <= HUNT;
              sync_lock <= 1'b0;
            end
          end else if (next) begin
            word_q[bit_count] <= serial_signal;
            bit_count         <= bit_count + 1'b1;
          end
        end
        default: begin
          state     <= RESET_STATE;
          sync_lock <= RESET_LOCK;
        end
      endcase
    end
  end

endmodule
